// File: rtl/rob_multiwb.sv
// rob_multiwb: reorder buffer with in-order commit and NUM_WB writeback ports.
//
// It accepts one renamed instruction per cycle. Results arrive out of order on
// the writeback ports, and the buffer retires at most one instruction per cycle
// from the head, in program order. When a mispredicted branch retires, the
// whole buffer is flushed.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   rdy                 global enable; when low, all state holds
//   disp_*              dispatch request (valid, rd, done, val) and
//                       response (ready, tag)
//   full, empty         occupancy status
//   src{1,2}_tag/rdy/val  operand lookup for dispatch. The value is returned
//                       when it is ready; otherwise the zero-extended tag.
//   wb_*                packed writeback ports; port i sits at slice i
//   commit_*            head retirement (valid, tag, rd, val, we)
//   flush, flush_pc     redirect when a mispredicted branch commits
module rob_multiwb #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int XLEN   = 32,
  parameter int NUM_WB = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     disp_valid,
  input  logic [4:0]               disp_rd,
  input  logic                     disp_done,
  input  logic [XLEN-1:0]          disp_val,
  output logic                     disp_ready,
  output logic [IDX_W-1:0]         disp_tag,
  output logic                     full,
  output logic                     empty,
  input  logic [IDX_W-1:0]         src1_tag,
  input  logic [IDX_W-1:0]         src2_tag,
  output logic                     src1_rdy,
  output logic                     src2_rdy,
  output logic [XLEN-1:0]          src1_val,
  output logic [XLEN-1:0]          src2_val,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*IDX_W-1:0]  wb_tag,
  input  logic [NUM_WB*XLEN-1:0]   wb_val,
  input  logic [NUM_WB-1:0]        wb_redir,
  input  logic [NUM_WB*XLEN-1:0]   wb_target,
  output logic                     commit_valid,
  output logic [IDX_W-1:0]         commit_tag,
  output logic [4:0]               commit_rd,
  output logic [XLEN-1:0]          commit_val,
  output logic                     commit_we,
  output logic                     flush,
  output logic [XLEN-1:0]          flush_pc
);

  localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] done;
  logic [DEPTH-1:0] redir;
  logic [4:0]       rd_q     [DEPTH];
  logic [XLEN-1:0]  val_q    [DEPTH];
  logic [XLEN-1:0]  target_q [DEPTH];

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;

  // Per-port views of the packed writeback buses.
  logic [IDX_W-1:0] wb_tag_a    [NUM_WB];
  logic [XLEN-1:0]  wb_val_a    [NUM_WB];
  logic [XLEN-1:0]  wb_target_a [NUM_WB];

  always_comb begin
    for (int i = 0; i < NUM_WB; i++) begin
      wb_tag_a[i]    = wb_tag[i*IDX_W +: IDX_W];
      wb_val_a[i]    = wb_val[i*XLEN +: XLEN];
      wb_target_a[i] = wb_target[i*XLEN +: XLEN];
    end
  end

  // Status and retirement.
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign commit_valid = rdy & busy[head] & done[head];
  assign commit_tag   = head;
  assign commit_rd    = rd_q[head];
  assign commit_val   = val_q[head];
  assign commit_we    = commit_valid & (rd_q[head] != 5'd0);
  assign flush        = commit_valid & redir[head];
  assign flush_pc     = target_q[head];

  // The full check uses the occupancy before this cycle's commit, so a slot
  // that frees this cycle cannot be reused until the next cycle. A flush
  // wipes the buffer, so any dispatch in the flush cycle is refused.
  assign disp_ready = disp_valid & rdy & ~full & ~flush;
  assign disp_tag   = tail;

  // Operand lookup. A matching writeback in the same cycle overrides the
  // stored value. The loop walks from the highest port down, so the lowest
  // matching port is assigned last and wins.
  always_comb begin
    src1_rdy = done[src1_tag];
    src1_val = done[src1_tag] ? val_q[src1_tag] : {{(XLEN-IDX_W){1'b0}}, src1_tag};
    src2_rdy = done[src2_tag];
    src2_val = done[src2_tag] ? val_q[src2_tag] : {{(XLEN-IDX_W){1'b0}}, src2_tag};
    for (int i = NUM_WB-1; i >= 0; i--) begin
      if (wb_valid[i] && (wb_tag_a[i] == src1_tag)) begin
        src1_rdy = 1'b1;
        src1_val = wb_val_a[i];
      end
      if (wb_valid[i] && (wb_tag_a[i] == src2_tag)) begin
        src2_rdy = 1'b1;
        src2_val = wb_val_a[i];
      end
    end
  end

  // State update. Entry payload (rd/val/target) carries no reset, because it
  // is only observed once busy/done mark it valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      done  <= '0;
      redir <= '0;
    end else if (rdy) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
        done  <= '0;
        redir <= '0;
      end else begin
        // The highest port is written first, so the lowest port's write to a
        // shared tag lands last and takes effect.
        for (int i = NUM_WB-1; i >= 0; i--) begin
          if (wb_valid[i] && busy[wb_tag_a[i]]) begin
            done[wb_tag_a[i]]     <= 1'b1;
            val_q[wb_tag_a[i]]    <= wb_val_a[i];
            redir[wb_tag_a[i]]    <= wb_redir[i];
            target_q[wb_tag_a[i]] <= wb_target_a[i];
          end
        end

        if (commit_valid) begin
          busy[head] <= 1'b0;
          head       <= head + IDX_ONE;
        end

        // The tail slot is never busy here, so it cannot collide with a
        // writeback above.
        if (disp_ready) begin
          busy[tail]  <= 1'b1;
          done[tail]  <= disp_done;
          redir[tail] <= 1'b0;
          rd_q[tail]  <= disp_rd;
          val_q[tail] <= disp_val;
          tail        <= tail + IDX_ONE;
        end

        case ({disp_ready, commit_valid})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rob_multiwb.sv
// Self-checking bench for rob_multiwb. The stimulus process updates a
// program-order queue model and pushes per-cycle expectations. A negedge
// monitor pops those expectations and compares them against the DUT outputs.
module tb_rob_multiwb;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;
  localparam int XLEN   = 32;
  localparam int NUM_WB = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    rdy = 1'b0;
  logic                    disp_valid = 1'b0;
  logic [4:0]              disp_rd = '0;
  logic                    disp_done = 1'b0;
  logic [XLEN-1:0]         disp_val = '0;
  logic                    disp_ready;
  logic [IDX_W-1:0]        disp_tag;
  logic                    full, empty;
  logic [IDX_W-1:0]        src1_tag = '0, src2_tag = '0;
  logic                    src1_rdy, src2_rdy;
  logic [XLEN-1:0]         src1_val, src2_val;
  logic [NUM_WB-1:0]       wb_valid = '0;
  logic [NUM_WB*IDX_W-1:0] wb_tag = '0;
  logic [NUM_WB*XLEN-1:0]  wb_val = '0;
  logic [NUM_WB-1:0]       wb_redir = '0;
  logic [NUM_WB*XLEN-1:0]  wb_target = '0;
  logic                    commit_valid;
  logic [IDX_W-1:0]        commit_tag;
  logic [4:0]              commit_rd;
  logic [XLEN-1:0]         commit_val;
  logic                    commit_we;
  logic                    flush;
  logic [XLEN-1:0]         flush_pc;

  rob_multiwb #(.DEPTH(DEPTH), .IDX_W(IDX_W), .XLEN(XLEN), .NUM_WB(NUM_WB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_done(disp_done), .disp_val(disp_val),
    .disp_ready(disp_ready), .disp_tag(disp_tag), .full(full), .empty(empty),
    .src1_tag(src1_tag), .src2_tag(src2_tag), .src1_rdy(src1_rdy), .src2_rdy(src2_rdy),
    .src1_val(src1_val), .src2_val(src2_val),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val), .wb_redir(wb_redir),
    .wb_target(wb_target),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
    .commit_val(commit_val), .commit_we(commit_we), .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [4:0] rd;
    bit         done;
    logic [31:0] val;
    bit         redir;
    logic [31:0] target;
  } ent_t;

  typedef struct {
    bit          dr;
    int          dtag;
    bit          full;
    bit          empty;
    bit          cv;
    bit          fl;
    bit          chk_src;
    bit          s1r;
    logic [31:0] s1v;
    bit          s2r;
    logic [31:0] s2v;
  } stat_t;

  typedef struct {
    int          tag;
    logic [4:0]  rd;
    logic [31:0] val;
    bit          we;
    bit          fl;
    logic [31:0] pc;
  } cmt_t;

  ent_t  mq[$];
  int    m_tail = 0;
  stat_t stat_q[$];
  cmt_t  cmt_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find(input int tag);
    for (int k = 0; k < mq.size(); k++)
      if (mq[k].tag == tag) return k;
    return -1;
  endfunction

  // Ready means the entry is complete, or some port is delivering its result
  // this cycle (the first such port supplies the value).
  function automatic void lookup(input int tag, output bit r, output logic [31:0] v);
    int k;
    k = find(tag);
    r = 1'b0;
    v = 32'(tag);
    if (k >= 0 && mq[k].done) begin
      r = 1'b1;
      v = mq[k].val;
    end
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_valid[p] && int'(wb_tag[p*IDX_W +: IDX_W]) == tag) begin
        r = 1'b1;
        v = wb_val[p*XLEN +: XLEN];
        break;
      end
    end
  endfunction

  task automatic clr_in();
    rst = 1'b1; rdy = 1'b1;
    disp_valid = 1'b0; disp_rd = '0; disp_done = 1'b0; disp_val = '0;
    wb_valid = '0; wb_tag = '0; wb_val = '0; wb_redir = '0; wb_target = '0;
    src1_tag = '0; src2_tag = '0;
  endtask

  task automatic set_wb(input int p, input int tag, input logic [31:0] v,
                        input bit rd, input logic [31:0] tg);
    wb_valid[p] = 1'b1;
    wb_tag[p*IDX_W +: IDX_W] = IDX_W'(tag);
    wb_val[p*XLEN +: XLEN] = v;
    wb_redir[p] = rd;
    wb_target[p*XLEN +: XLEN] = tg;
  endtask

  task automatic disp(input int rd, input bit dn, input logic [31:0] v);
    disp_valid = 1'b1; disp_rd = 5'(rd); disp_done = dn; disp_val = v;
  endtask

  // Predict this cycle's outputs from the current inputs, advance one clock,
  // then apply the same inputs to the model.
  task automatic step();
    stat_t s;
    cmt_t  c;
    ent_t  e;
    bit    r1, r2;
    logic [31:0] v1, v2;
    s.full  = (mq.size() == DEPTH);
    s.empty = (mq.size() == 0);
    s.cv    = 1'b0;
    s.fl    = 1'b0;
    if (rdy && mq.size() > 0) begin
      if (mq[0].done) begin
        s.cv = 1'b1;
        s.fl = mq[0].redir;
      end
    end
    s.dr   = disp_valid && rdy && !s.full && !s.fl;
    s.dtag = m_tail;
    s.chk_src = (find(int'(src1_tag)) >= 0) && (find(int'(src2_tag)) >= 0);
    lookup(int'(src1_tag), r1, v1);
    lookup(int'(src2_tag), r2, v2);
    s.s1r = r1; s.s1v = v1; s.s2r = r2; s.s2v = v2;
    stat_q.push_back(s);
    if (s.cv) begin
      c.tag = mq[0].tag; c.rd = mq[0].rd; c.val = mq[0].val;
      c.we = (mq[0].rd != 5'd0); c.fl = s.fl; c.pc = mq[0].target;
      cmt_q.push_back(c);
    end
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      m_tail = 0;
    end else if (rdy) begin
      if (s.fl) begin
        mq.delete();
        m_tail = 0;
      end else begin
        for (int k = 0; k < mq.size(); k++) begin
          for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p] && int'(wb_tag[p*IDX_W +: IDX_W]) == mq[k].tag) begin
              e = mq[k];
              e.done = 1'b1;
              e.val = wb_val[p*XLEN +: XLEN];
              e.redir = wb_redir[p];
              e.target = wb_target[p*XLEN +: XLEN];
              mq[k] = e;
              break;
            end
          end
        end
        if (s.cv) void'(mq.pop_front());
        if (s.dr) begin
          e.tag = m_tail; e.rd = disp_rd; e.done = disp_done; e.val = disp_val;
          e.redir = 1'b0; e.target = '0;
          mq.push_back(e);
          m_tail = (m_tail + 1) % DEPTH;
        end
      end
    end
    #1;
  endtask

  task automatic rand_inputs();
    int t;
    rst = ($urandom_range(0, 399) != 0);
    rdy = ($urandom_range(0, 9) != 0);
    disp_valid = ($urandom_range(0, 9) < 7);
    disp_rd = 5'($urandom);
    disp_done = ($urandom_range(0, 9) < 3);
    disp_val = $urandom;
    for (int p = 0; p < NUM_WB; p++) begin
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        t = mq[$urandom_range(0, mq.size()-1)].tag;
      else
        t = $urandom_range(0, DEPTH-1);
      wb_valid[p] = ($urandom_range(0, 9) < 4);
      wb_tag[p*IDX_W +: IDX_W] = IDX_W'(t);
      wb_val[p*XLEN +: XLEN] = $urandom;
      wb_redir[p] = ($urandom_range(0, 24) == 0);
      wb_target[p*XLEN +: XLEN] = $urandom;
    end
    if (mq.size() > 0) begin
      src1_tag = IDX_W'(mq[$urandom_range(0, mq.size()-1)].tag);
      src2_tag = IDX_W'(mq[$urandom_range(0, mq.size()-1)].tag);
    end else begin
      src1_tag = IDX_W'($urandom);
      src2_tag = IDX_W'($urandom);
    end
  endtask

  always @(negedge clk) begin
    stat_t s;
    cmt_t  c;
    if (mon_en) begin
      if (stat_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL stat_underflow: got none expected record at %0t", $time);
      end else begin
        s = stat_q.pop_front();
        check("disp_ready", 64'(disp_ready), 64'(s.dr));
        check("disp_tag", 64'(disp_tag), 64'(s.dtag));
        check("full", 64'(full), 64'(s.full));
        check("empty", 64'(empty), 64'(s.empty));
        check("commit_valid", 64'(commit_valid), 64'(s.cv));
        check("flush", 64'(flush), 64'(s.fl));
        if (s.chk_src) begin
          check("src1_rdy", 64'(src1_rdy), 64'(s.s1r));
          check("src1_val", 64'(src1_val), 64'(s.s1v));
          check("src2_rdy", 64'(src2_rdy), 64'(s.s2r));
          check("src2_val", 64'(src2_val), 64'(s.s2v));
        end
      end
      if (commit_valid === 1'b1) begin
        if (cmt_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL commit_unexpected: got tag %0h expected no commit at %0t", commit_tag, $time);
        end else begin
          c = cmt_q.pop_front();
          check("commit_tag", 64'(commit_tag), 64'(c.tag));
          check("commit_rd", 64'(commit_rd), 64'(c.rd));
          check("commit_val", 64'(commit_val), 64'(c.val));
          check("commit_we", 64'(commit_we), 64'(c.we));
          if (c.fl) check("flush_pc", 64'(flush_pc), 64'(c.pc));
        end
      end
    end
  end

  initial begin
    clr_in();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr_in();
    mon_en = 1'b1;
    step();                               // reset state: empty, tag 0

    // Fill all 16 entries, then a 17th attempt is refused.
    for (int i = 0; i < DEPTH; i++) begin
      clr_in(); disp(i + 1, 1'b0, 32'h100 + 32'(i)); step();
    end
    clr_in(); disp(30, 1'b0, 32'hdead); step();

    // Out-of-order writebacks 3,1,2,0; a bypass lookup on tag 7 rides along.
    clr_in(); set_wb(0, 3, 32'h333, 1'b0, 0); step();
    clr_in(); set_wb(0, 1, 32'h111, 1'b0, 0); step();
    clr_in(); set_wb(0, 2, 32'h222, 1'b0, 0); step();
    clr_in(); set_wb(0, 0, 32'h000, 1'b0, 0); set_wb(1, 7, 32'h1234, 1'b0, 0);
    src1_tag = 4'd7; src2_tag = 4'd4; step();

    // Both ports hit tag 5: port 0 must win.
    clr_in(); set_wb(0, 5, 32'haa, 1'b0, 0); set_wb(1, 5, 32'hbb, 1'b0, 0); step();
    for (int t = 4; t < DEPTH; t++) begin
      if (t != 5 && t != 7) begin
        clr_in(); set_wb(0, t, 32'(t) * 32'h11, 1'b0, 0); step();
      end
    end
    clr_in(); repeat (20) step();

    // Mispredicted branch at head; dispatch in the flush cycle is refused.
    for (int i = 0; i < 3; i++) begin
      clr_in(); disp(5 + i, 1'b0, 0); step();
    end
    clr_in(); set_wb(0, 0, 32'h55, 1'b1, 32'h80); step();
    clr_in(); disp(9, 1'b0, 32'h9); step();
    clr_in(); step();

    // rdy low for 3 cycles with writeback and dispatch pending.
    for (int i = 0; i < 4; i++) begin
      clr_in(); disp(10 + i, 1'b0, 0); step();
    end
    clr_in(); rdy = 1'b0; set_wb(0, 0, 32'h77, 1'b0, 0); disp(20, 1'b1, 32'h20);
    repeat (3) step();
    clr_in(); repeat (2) step();

    // Reset with 6 entries live.
    for (int i = 0; i < 2; i++) begin
      clr_in(); disp(14 + i, 1'b0, 0); step();
    end
    clr_in(); rst = 1'b0; set_wb(0, 1, 32'h1, 1'b0, 0); disp(3, 1'b1, 32'h3); step();
    clr_in(); step();
    clr_in(); step();

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      rand_inputs();
      step();
    end

    mon_en = 1'b0;
    check("commit_queue_drained", 64'(cmt_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
